// File: rtl/switch_poller.sv
// switch_poller
//   Avalon-MM read master that polls the switch PIO slave. Each sample is
//   debounced across consecutive polls. The stable vector is then published
//   together with a one-cycle change pulse and a change mask.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-high reset
//   enable           polling enable; low freezes the poll timer while idle
//   avm_address      read address, constant BASE_ADDR
//   avm_read         registered read request
//   avm_waitrequest  slave stall; a read is accepted when read=1 and waitrequest=0
//   avm_readdata     read data; only bits [DATA_WIDTH-1:0] are used
//   switches_out     debounced switch vector
//   changed          one-cycle pulse when switches_out updates
//   change_mask      new XOR previous switches_out, held until the next update
module switch_poller #(
  parameter int POLL_PERIOD  = 50000,
  parameter int STABLE_COUNT = 4,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 2,
  parameter int BASE_ADDR    = 0,
  parameter int DATA_WIDTH   = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           avm_readdata,
  output logic [DATA_WIDTH-1:0] switches_out,
  output logic                  changed,
  output logic [DATA_WIDTH-1:0] change_mask
);

  localparam int TMR_W = (POLL_PERIOD  > 1) ? $clog2(POLL_PERIOD)  : 1;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int CNT_W = $clog2(STABLE_COUNT + 1);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(POLL_PERIOD - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WAIT   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t                  state;
  logic [TMR_W-1:0]        timer;
  logic [LAT_W-1:0]        lat_cnt;
  logic [DATA_WIDTH-1:0]   sample_p0;
  logic                    vld_p0;
  logic [DATA_WIDTH-1:0]   candidate;
  logic [CNT_W-1:0]        stable_cnt;
  logic [CNT_W-1:0]        stable_nxt;

  // Saturating increment of the run-length counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    sat_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  // The address never changes; the slave exposes a single data register.
  assign avm_address = ADDR_WIDTH'(BASE_ADDR);

  // The upper readdata bits are deliberately ignored.
  generate
    if (DATA_WIDTH < 32) begin : g_unused_upper
      logic unused_upper;
      assign unused_upper = ^avm_readdata[31:DATA_WIDTH];
    end
  endgenerate

  // A matching sample extends the run. A differing one starts a new run of
  // length one. The candidate always becomes the latest sample.
  always_comb begin
    stable_nxt = CNT_ONE;
    if (sample_p0 == candidate) begin
      stable_nxt = sat_inc(stable_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= TMR_LOAD;
      lat_cnt      <= '0;
      avm_read     <= 1'b0;
      sample_p0    <= '0;
      vld_p0       <= 1'b0;
      candidate    <= '0;
      stable_cnt   <= '0;
      switches_out <= '0;
      change_mask  <= '0;
      changed      <= 1'b0;
    end else begin
      changed <= 1'b0;
      vld_p0  <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            if (timer == '0) begin
              state    <= READ;
              avm_read <= 1'b1;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end

        READ: begin
          if (!avm_waitrequest) begin
            state    <= WAIT;
            avm_read <= 1'b0;
            lat_cnt  <= LAT_LOAD;
          end
        end

        // p0: bus data captured into the sample register
        WAIT: begin
          if (lat_cnt == '0) begin
            sample_p0 <= avm_readdata[DATA_WIDTH-1:0];
            vld_p0    <= 1'b1;
            state     <= UPDATE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        // p0 -> outputs: debounce decision and publish
        UPDATE: begin
          state <= IDLE;
          timer <= TMR_LOAD;
          if (vld_p0) begin
            candidate  <= sample_p0;
            stable_cnt <= stable_nxt;
            if ((stable_nxt == CNT_MAX) && (sample_p0 != switches_out)) begin
              switches_out <= sample_p0;
              change_mask  <= sample_p0 ^ switches_out;
              changed      <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_poller.sv
// Bench for switch_poller. Instance 0: POLL_PERIOD=4, STABLE_COUNT=3,
// READ_LATENCY=1. Instance 1: POLL_PERIOD=4, STABLE_COUNT=1, READ_LATENCY=3.
// Each instance has a slave model. The model drives the programmed value only
// in the cycle READ_LATENCY after acceptance and drives its complement otherwise.
module tb_switch_poller;

  localparam int LA = 1;
  localparam int LB = 3;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  wr;
  logic [1:0]  rd;
  logic [1:0]  chg;
  logic [1:0]  addr [2];
  logic [17:0] sw   [2];
  logic [17:0] mask [2];
  logic [17:0] val  [2];
  logic [31:0] rdata[2];
  logic [13:0] upper;
  int          cd   [2];
  int          pulses0;
  int          n_cmp;
  int          n_err;

  switch_poller #(.POLL_PERIOD(4), .STABLE_COUNT(3), .READ_LATENCY(LA),
                  .ADDR_WIDTH(2), .BASE_ADDR(0), .DATA_WIDTH(18)) dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]),
    .avm_readdata(rdata[0]), .switches_out(sw[0]), .changed(chg[0]),
    .change_mask(mask[0]));

  switch_poller #(.POLL_PERIOD(4), .STABLE_COUNT(1), .READ_LATENCY(LB),
                  .ADDR_WIDTH(2), .BASE_ADDR(0), .DATA_WIDTH(18)) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]),
    .avm_readdata(rdata[1]), .switches_out(sw[1]), .changed(chg[1]),
    .change_mask(mask[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave models: countdown starts at the acceptance edge.
  always @(posedge clk) begin
    if (reset) begin
      cd[0] <= 0;
      cd[1] <= 0;
    end else begin
      if (rd[0] && !wr[0]) cd[0] <= LA; else if (cd[0] != 0) cd[0] <= cd[0] - 1;
      if (rd[1] && !wr[1]) cd[1] <= LB; else if (cd[1] != 0) cd[1] <= cd[1] - 1;
    end
  end

  assign rdata[0] = {upper, (cd[0] == 1) ? val[0] : ~val[0]};
  assign rdata[1] = {upper, (cd[1] == 1) ? val[1] : ~val[1]};

  always @(negedge clk) if (chg[0]) pulses0 <= pulses0 + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Waits for the next read of instance i, serves value v after `stall`
  // waitrequest cycles, then checks the published outputs.
  task automatic poll(input int i, input logic [17:0] v, input int stall,
                      input logic [17:0] esw, input logic echg,
                      input logic [17:0] emask, output int waited);
    int lat;
    lat    = (i == 0) ? LA : LB;
    waited = 0;
    while (rd[i] !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (rd[i] !== 1'b1) begin
      chk("poll_timeout", 32'd0, 32'd1);
      return;
    end
    val[i] = v;
    if (stall > 0) begin
      wr[i] = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_read", {31'd0, rd[i]}, 32'd1);
        chk("stall_addr", {30'd0, addr[i]}, 32'd0);
      end
      wr[i] = 1'b0;
    end
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      if (k == 1) chk("read_drop", {31'd0, rd[i]}, 32'd0);
    end
    chk("switches", {14'd0, sw[i]}, {14'd0, esw});
    chk("changed", {31'd0, chg[i]}, {31'd0, echg});
    chk("mask", {14'd0, mask[i]}, {14'd0, emask});
    @(negedge clk);
    chk("chg_single", {31'd0, chg[i]}, 32'd0);
  endtask

  // Directed sequence for instance 0 (STABLE_COUNT=3): idle polls,
  // steady 0x5, bounce 1,2,1,1,1, then a poll stalled 5 cycles.
  logic [17:0] tv   [13] = '{18'h0, 18'h0, 18'h0, 18'h5, 18'h5, 18'h5, 18'h5,
                             18'h1, 18'h2, 18'h1, 18'h1, 18'h1, 18'h1};
  logic [17:0] tsw  [13] = '{18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h5, 18'h5,
                             18'h5, 18'h5, 18'h5, 18'h5, 18'h1, 18'h1};
  logic        tchg [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [17:0] tmsk [13] = '{18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h5, 18'h5,
                             18'h5, 18'h5, 18'h5, 18'h5, 18'h4, 18'h4};
  int          tstl [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5};

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int snap;
    bit saw;
    n_cmp   = 0;
    n_err   = 0;
    pulses0 = 0;
    reset   = 1'b1;
    enable  = 1'b1;
    wr      = 2'b00;
    val[0]  = '0;
    val[1]  = '0;
    upper   = '0;
    repeat (3) @(negedge clk);

    chk("rst_read_a", {31'd0, rd[0]}, 32'd0);
    chk("rst_read_b", {31'd0, rd[1]}, 32'd0);
    chk("rst_addr", {30'd0, addr[0]}, 32'd0);
    chk("rst_sw", {14'd0, sw[0]}, 32'd0);
    chk("rst_chg", {31'd0, chg[0]}, 32'd0);
    chk("rst_mask", {14'd0, mask[0]}, 32'd0);

    reset = 1'b0;
    for (int p = 0; p < 13; p++) begin
      poll(0, tv[p], tstl[p], tsw[p], tchg[p], tmsk[p], w);
      chk((p == 0) ? "first_read_cycle" : "poll_interval", w, (p == 0) ? 32'd4 : 32'd3);
    end
    chk("pulse_count", pulses0, 32'd2);

    // Upper readdata bits set, lower bits equal to the current output.
    upper = 14'h3FFF;
    for (int p = 0; p < 3; p++) poll(0, 18'h1, 0, 18'h1, 1'b0, 18'h4, w);
    upper = '0;
    chk("upper_no_pulse", pulses0, 32'd2);

    // Poll timer frozen while disabled, resumes from the held value.
    enable = 1'b0;
    saw    = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rd[0]) saw = 1'b1;
    end
    chk("en_no_read", {31'd0, saw}, 32'd0);
    enable = 1'b1;
    poll(0, 18'h1, 0, 18'h1, 1'b0, 18'h4, w);
    chk("en_resume", w, 32'd3);

    // Reset during WAIT while the slave drives all ones.
    snap = pulses0;
    w    = 0;
    while (rd[0] !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_seen_read", {31'd0, rd[0]}, 32'd1);
    val[0] = 18'h3FFFF;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_read", {31'd0, rd[0]}, 32'd0);
    chk("rst_mid_sw", {14'd0, sw[0]}, 32'd0);
    chk("rst_mid_chg", {31'd0, chg[0]}, 32'd0);
    chk("rst_mid_mask", {14'd0, mask[0]}, 32'd0);
    @(negedge clk);
    val[0] = '0;
    reset  = 1'b0;
    poll(0, 18'h0, 0, 18'h0, 1'b0, 18'h0, w);
    chk("rst_mid_restart", w, 32'd4);
    chk("rst_mid_no_pulse", pulses0, snap);

    // Instance 1: STABLE_COUNT=1, READ_LATENCY=3.
    poll(1, 18'h0002A, 0, 18'h0002A, 1'b1, 18'h0002A, w);
    poll(1, 18'h00015, 0, 18'h00015, 1'b1, 18'h0003F, w);
    chk("b_interval", w, 32'd3);
    poll(1, 18'h00015, 2, 18'h00015, 1'b0, 18'h0003F, w);
    chk("b_interval_stall", w, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
